// File: rtl/mask_pkg.sv
// Shared types and constants for the green-screen mask bounding-box tracker.
// Optional pixel counting is enabled by defining MASK_BBOX_COUNT_EN.
package mask_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;
    localparam int MIN_RUN_DEF  = 4;
    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;
    localparam int RUN_W        = 5;
    localparam int COUNT_W      = 20;

    typedef struct packed {
        logic [HCOUNT_W-1:0] x_min;
        logic [HCOUNT_W-1:0] x_max;
        logic [VCOUNT_W-1:0] y_min;
        logic [VCOUNT_W-1:0] y_max;
        logic                found;
    } bbox_t;

    localparam bbox_t BBOX_INIT = '{
        x_min: 11'd2047, x_max: 11'd0, y_min: 10'd1023, y_max: 10'd0, found: 1'b0
    };

    // An empty frame reports an all-zero box rather than the sentinel extremes.
    function automatic bbox_t bbox_publish(input bbox_t acc);
        bbox_t res;
        if (acc.found) begin
            res = acc;
        end else begin
            res = '{x_min: 11'd0, x_max: 11'd0, y_min: 10'd0, y_max: 10'd0, found: 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/mask_bbox_if.sv
// Pixel stream carrying the 1-bit foreground mask and its raster position.
interface mask_bbox_if;
    logic        valid_in;
    logic        bit_mask_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;

    modport master (output valid_in, output bit_mask_in, output hcount_in, output vcount_in);
    modport slave  (input  valid_in, input  bit_mask_in, input  hcount_in, input  vcount_in);
endinterface

// File: rtl/mask_bbox_run_qualifier.sv
// Saturating horizontal run counter: flags foreground pixels that belong to a
// run of at least MIN_RUN consecutive pixels on the same line.
module run_qualifier
    import mask_pkg::*;
#(
    parameter int MIN_RUN = MIN_RUN_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pixel_valid,
    input  logic pixel_active,
    input  logic bit_mask,
    input  logic line_start,
    output logic qualified,
    output logic first_qualify
);
    localparam logic [RUN_W-1:0] MIN_RUN_C = RUN_W'(MIN_RUN);

    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] base_s;
    logic [RUN_W-1:0] next_s;
    logic             fg_s;

    // Post-increment run length, with the line start forcing a fresh run.
    always_comb begin
        fg_s   = pixel_active & bit_mask;
        base_s = line_start ? {RUN_W{1'b0}} : run_r;
        if (base_s >= MIN_RUN_C) begin
            next_s = MIN_RUN_C;
        end else begin
            next_s = base_s + 5'd1;
        end
        qualified     = fg_s && (next_s == MIN_RUN_C);
        first_qualify = qualified && (base_s != MIN_RUN_C);
    end

    // Run length register; background and blanking pixels end the run.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            run_r <= {RUN_W{1'b0}};
        end else if (pixel_valid) begin
            run_r <= fg_s ? next_s : {RUN_W{1'b0}};
        end else begin
            run_r <= run_r;
        end
    end
endmodule

// File: rtl/mask_bbox.sv
// Per-frame foreground bounding box with run-length noise rejection.
// Define MASK_BBOX_COUNT_EN to add pixel_count_out (qualified pixel count).
module mask_bbox
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int MIN_RUN  = MIN_RUN_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mask_bbox_if.slave          pix,
    output logic [HCOUNT_W-1:0] x_min_out,
    output logic [HCOUNT_W-1:0] x_max_out,
    output logic [VCOUNT_W-1:0] y_min_out,
    output logic [VCOUNT_W-1:0] y_max_out,
    output logic                found_out,
    output logic                frame_done_out
`ifdef MASK_BBOX_COUNT_EN
    ,
    output logic [COUNT_W-1:0]  pixel_count_out
`endif
);
    logic                active_s;
    logic                frame_end_s;
    logic                qualified_s;
    logic                first_s;
    logic [HCOUNT_W-1:0] left_s;
    bbox_t               acc_r;
    bbox_t               acc_nxt_s;
    bbox_t               pub_s;

    // Classify the incoming pixel and spot the last active pixel of the frame.
    always_comb begin
        active_s    = pix.valid_in && (pix.hcount_in < HCOUNT_W'(H_ACTIVE))
                                   && (pix.vcount_in < VCOUNT_W'(V_ACTIVE));
        frame_end_s = active_s && (pix.hcount_in == HCOUNT_W'(H_ACTIVE - 1))
                               && (pix.vcount_in == VCOUNT_W'(V_ACTIVE - 1));
    end

    run_qualifier #(.MIN_RUN(MIN_RUN)) u_run (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pixel_valid   (pix.valid_in),
        .pixel_active  (active_s),
        .bit_mask      (pix.bit_mask_in),
        .line_start    (pix.hcount_in == 11'd0),
        .qualified     (qualified_s),
        .first_qualify (first_s)
    );

    // Fold a qualified pixel into the box; a run's first hit reaches back to its left edge.
    always_comb begin
        acc_nxt_s = acc_r;
        left_s    = pix.hcount_in;
        if (qualified_s) begin
            if (first_s) begin
                left_s = pix.hcount_in - HCOUNT_W'(MIN_RUN - 1);
            end else begin
                left_s = pix.hcount_in;
            end
            if (left_s < acc_r.x_min)         acc_nxt_s.x_min = left_s;
            else                              acc_nxt_s.x_min = acc_r.x_min;
            if (pix.hcount_in > acc_r.x_max)  acc_nxt_s.x_max = pix.hcount_in;
            else                              acc_nxt_s.x_max = acc_r.x_max;
            if (pix.vcount_in < acc_r.y_min)  acc_nxt_s.y_min = pix.vcount_in;
            else                              acc_nxt_s.y_min = acc_r.y_min;
            if (pix.vcount_in > acc_r.y_max)  acc_nxt_s.y_max = pix.vcount_in;
            else                              acc_nxt_s.y_max = acc_r.y_max;
            acc_nxt_s.found = 1'b1;
        end else begin
            acc_nxt_s = acc_r;
        end
        pub_s = bbox_publish(acc_nxt_s);
    end

    // Accumulator register, re-armed as the finished frame is published.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_r <= BBOX_INIT;
        end else if (frame_end_s) begin
            acc_r <= BBOX_INIT;
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

    // Published result and one-cycle done strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_min_out      <= 11'd0;
            x_max_out      <= 11'd0;
            y_min_out      <= 10'd0;
            y_max_out      <= 10'd0;
            found_out      <= 1'b0;
            frame_done_out <= 1'b0;
        end else if (frame_end_s) begin
            x_min_out      <= pub_s.x_min;
            x_max_out      <= pub_s.x_max;
            y_min_out      <= pub_s.y_min;
            y_max_out      <= pub_s.y_max;
            found_out      <= pub_s.found;
            frame_done_out <= 1'b1;
        end else begin
            frame_done_out <= 1'b0;
        end
    end

`ifdef MASK_BBOX_COUNT_EN
    logic [COUNT_W-1:0] cnt_r;
    logic [COUNT_W-1:0] cnt_nxt_s;

    // A run's first hit credits the whole MIN_RUN prefix at once.
    always_comb begin
        if (first_s) begin
            cnt_nxt_s = cnt_r + COUNT_W'(MIN_RUN);
        end else if (qualified_s) begin
            cnt_nxt_s = cnt_r + 20'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pixel count accumulator and its published copy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_r           <= 20'd0;
            pixel_count_out <= 20'd0;
        end else if (frame_end_s) begin
            cnt_r           <= 20'd0;
            pixel_count_out <= pub_s.found ? cnt_nxt_s : 20'd0;
        end else begin
            cnt_r           <= cnt_nxt_s;
        end
    end
`endif
endmodule
